// File: rtl/sha384_msg_ctrl_pkg.sv
// sha384_msg_ctrl_pkg: SHA-384/512 widths, IV and message controller state encoding.
package sha384_msg_ctrl_pkg;
    localparam int WORD_W = 64;
    localparam int NWORDS = 16;
    localparam int BLK_W  = WORD_W * NWORDS;
    localparam int CV_W   = 512;
    localparam int DIG_W  = 384;

    localparam logic [CV_W-1:0] SHA384_IV = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507,
        64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511,
        64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };

    localparam logic [WORD_W-1:0] PAD_WORD = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HASH, S_PAD, S_DONE} state_t;

    // keep the first n bytes of d and place the 0x80 marker at byte n (none when n=8)
    function automatic logic [WORD_W-1:0] last_word(input logic [WORD_W-1:0] d, input logic [3:0] n);
        return (d & ~({WORD_W{1'b1}} >> {n, 3'b000})) | (PAD_WORD >> {n, 3'b000});
    endfunction
endpackage

// File: rtl/sha384_msg_ctrl.sv
// sha384_msg_ctrl: buffers, pads and sequences SHA-384 message blocks into an
// external sha512_core, chaining vout between blocks and presenting the digest.
module sha384_msg_ctrl #(
    parameter int LEN_W = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [63:0]   i_data,
    input  logic          i_last,
    input  logic [3:0]    i_bytes,
    output logic          o_ready,
    output logic          o_core_start,
    output logic [1023:0] o_core_data,
    output logic [511:0]  o_core_vin,
    input  logic [511:0]  i_core_vout,
    input  logic          i_core_done,
    output logic [383:0]  o_hash,
    output logic          o_hash_valid,
    output logic          o_busy
);
    import sha384_msg_ctrl_pkg::*;

    state_t            r_state, w_next;
    logic [3:0]        r_widx;
    logic [LEN_W-1:0]  r_len;
    logic [WORD_W-1:0] r_buf [NWORDS];
    logic [CV_W-1:0]   r_vin;
    logic [DIG_W-1:0]  r_hash;
    logic              r_start, r_final, r_pad, r_pad80;

    logic              w_acc, w_short, w_done;
    logic [3:0]        w_n;
    logic [4:0]        w_k, w_p;
    logic [LEN_W-1:0]  w_len;
    logic [WORD_W-1:0] w_fill [NWORDS];

    assign o_ready      = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign o_busy       = r_state != S_IDLE;
    assign o_hash_valid = r_state == S_DONE;
    assign o_core_start = r_start;
    assign o_core_vin   = r_vin;
    assign o_hash       = r_hash;

    assign w_acc   = i_valid && o_ready;
    assign w_n     = (i_bytes > 4'd8) ? 4'd8 : i_bytes;
    assign w_k     = {1'b0, r_widx};
    assign w_p     = w_k + 5'(w_n == 4'd8);
    assign w_short = w_p <= 5'd13;
    assign w_len   = r_len + (i_last ? LEN_W'({w_n, 3'b000}) : LEN_W'(WORD_W));
    // the core's done is only trusted from the cycle after the start pulse
    assign w_done  = (r_state == S_HASH) && !r_start && i_core_done;

    for (genvar i = 0; i < NWORDS; i++) begin : g_data
        assign o_core_data[BLK_W-1-WORD_W*i -: WORD_W] = r_buf[i];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_LOAD: w_next = !w_acc ? r_state : (i_last || r_widx == 4'd15) ? S_HASH : S_LOAD;
            S_HASH:         w_next = !w_done ? S_HASH : r_final ? S_DONE : r_pad ? S_PAD : S_LOAD;
            S_PAD:          w_next = S_HASH;
            S_DONE:         w_next = S_IDLE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        for (int j = 0; j < NWORDS; j++) begin
            w_fill[j] = (5'(j) < w_k) ? r_buf[j] : (5'(j) == w_k) ? last_word(i_data, w_n) :
                        (5'(j) == w_p) ? PAD_WORD : '0;
            if (w_short && j >= NWORDS - 2) w_fill[j] = (j == NWORDS - 1) ? WORD_W'(w_len) : '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_widx  <= '0;
            r_len   <= '0;
            r_vin   <= '0;
            r_hash  <= '0;
            r_start <= 1'b0;
            r_final <= 1'b0;
            r_pad   <= 1'b0;
            r_pad80 <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == S_HASH) && (r_state != S_HASH);
            if (r_state == S_IDLE && w_acc) r_vin <= SHA384_IV;
            if (w_acc) begin
                r_widx  <= r_widx + 4'd1;
                r_len   <= w_len;
                r_final <= i_last && w_short;
                r_pad   <= i_last && !w_short;
                r_pad80 <= w_p[4];
            end
            if (r_state == S_PAD) r_final <= 1'b1;
            if (w_done) begin
                r_vin  <= i_core_vout;
                r_widx <= '0;
                if (r_final) r_hash <= i_core_vout[CV_W-1 -: DIG_W];
            end
            if (r_state == S_DONE) r_len <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int j = 0; j < NWORDS; j++) begin
            if (w_acc && i_last) r_buf[j] <= w_fill[j];
            else if (w_acc && r_widx == 4'(j)) r_buf[j] <= i_data;
            else if (r_state == S_PAD)
                r_buf[j] <= (j == NWORDS - 1) ? WORD_W'(r_len) : (j == 0 && r_pad80) ? PAD_WORD : '0;
        end
    end
endmodule
